// File: rtl/guess_entry_if.sv
// -----------------------------------------------------------------------------
// guess_entry_if
// Bundles the keypad-side key strobe and the commit bus presented to the game
// controller.
//   key_valid / key_code : one-cycle key strobe from the keypad decoder
//   oNum1..oNum3         : digits of the last committed entry
//   oNumRdy              : one-cycle commit pulse
// master : keypad/controller side (drives keys, observes commits)
// slave  : guess_entry side (samples keys, drives commits)
// -----------------------------------------------------------------------------
interface guess_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] oNum1;
    logic [3:0] oNum2;
    logic [3:0] oNum3;
    logic       oNumRdy;

    modport master (
        output key_valid,
        output key_code,
        input  oNum1,
        input  oNum2,
        input  oNum3,
        input  oNumRdy
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output oNum1,
        output oNum2,
        output oNum3,
        output oNumRdy
    );
endinterface

// File: rtl/guess_entry.sv
// -----------------------------------------------------------------------------
// guess_entry
// Three-digit entry buffer between the keypad decoder and the game controller.
// Digits are appended in order, backspace removes the newest digit, clear
// empties the buffer, and ENTER on a full buffer commits the three digits to
// the controller with a one-cycle pulse. The first commit after reset is the
// secret answer; every later commit is a guess and is counted.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : key strobe in, committed digits + ready pulse out
//   oDig1..3   : live buffer contents for echo display (0 when empty)
//   oDigCnt    : number of buffered digits (0..3)
//   oErr       : one-cycle pulse when a key is rejected
//   oGuessCnt  : guesses committed after the answer, saturating at GUESS_MAX
//   oLocked    : high once oGuessCnt reaches GUESS_MAX
// -----------------------------------------------------------------------------
module guess_entry #(
    parameter int ALLOW_REPEAT = 0,
    parameter int GUESS_MAX    = 15
) (
    input  logic         clk,
    input  logic         reset,
    guess_entry_if.slave bus,
    output logic [3:0]   oDig1,
    output logic [3:0]   oDig2,
    output logic [3:0]   oDig3,
    output logic [1:0]   oDigCnt,
    output logic         oErr,
    output logic [3:0]   oGuessCnt,
    output logic         oLocked
);

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ILL_D = 4'hD;
    localparam logic [3:0] KEY_ILL_E = 4'hE;
    localparam logic [3:0] KEY_ILL_F = 4'hF;
    localparam logic [3:0] GMAX      = GUESS_MAX[3:0];
    localparam logic       REPEAT_CHECK = (ALLOW_REPEAT == 0);

    // Encoding equals the fill level so it can be driven straight onto oDigCnt.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } state_e;

    state_e     state_r, state_s;
    logic [3:0] dig1_r, dig2_r, dig3_r;
    logic [3:0] dig1_s, dig2_s, dig3_s;
    logic [3:0] num1_r, num2_r, num3_r;
    logic [3:0] num1_s, num2_s, num3_s;
    logic       rdy_r, rdy_s;
    logic       err_r, err_s;
    logic [3:0] gcnt_r, gcnt_s;
    logic       locked_r, locked_s;
    logic       ans_r, ans_s;

    // True when digit d already occupies one of the first cnt buffer slots.
    // Empty slots read as 0, so only filled slots may take part.
    function automatic logic is_dup(input logic [3:0] d, input logic [1:0] cnt,
                                    input logic [3:0] b1, input logic [3:0] b2,
                                    input logic [3:0] b3);
        return ((cnt >= 2'd1) && (d == b1)) ||
               ((cnt >= 2'd2) && (d == b2)) ||
               ((cnt >= 2'd3) && (d == b3));
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= EMPTY;
            dig1_r   <= 4'h0;
            dig2_r   <= 4'h0;
            dig3_r   <= 4'h0;
            num1_r   <= 4'h0;
            num2_r   <= 4'h0;
            num3_r   <= 4'h0;
            rdy_r    <= 1'b0;
            err_r    <= 1'b0;
            gcnt_r   <= 4'h0;
            locked_r <= 1'b0;
            ans_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            dig1_r   <= dig1_s;
            dig2_r   <= dig2_s;
            dig3_r   <= dig3_s;
            num1_r   <= num1_s;
            num2_r   <= num2_s;
            num3_r   <= num3_s;
            rdy_r    <= rdy_s;
            err_r    <= err_s;
            gcnt_r   <= gcnt_s;
            locked_r <= locked_s;
            ans_r    <= ans_s;
        end
    end

    // Key decode: next state, buffer edits, commit and error pulses.
    always_comb begin
        state_s  = state_r;
        dig1_s   = dig1_r;
        dig2_s   = dig2_r;
        dig3_s   = dig3_r;
        num1_s   = num1_r;
        num2_s   = num2_r;
        num3_s   = num3_r;
        rdy_s    = 1'b0;
        err_s    = 1'b0;
        gcnt_s   = gcnt_r;
        ans_s    = ans_r;
        locked_s = locked_r;

        if (bus.key_valid) begin
            case (bus.key_code)
                KEY_BKSP: begin
                    case (state_r)
                        ONE: begin
                            dig1_s  = 4'h0;
                            state_s = EMPTY;
                        end
                        TWO: begin
                            dig2_s  = 4'h0;
                            state_s = ONE;
                        end
                        FULL: begin
                            dig3_s  = 4'h0;
                            state_s = TWO;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
                KEY_ENTER: begin
                    if ((state_r == FULL) && !locked_r) begin
                        num1_s  = dig1_r;
                        num2_s  = dig2_r;
                        num3_s  = dig3_r;
                        rdy_s   = 1'b1;
                        dig1_s  = 4'h0;
                        dig2_s  = 4'h0;
                        dig3_s  = 4'h0;
                        state_s = EMPTY;
                        // First commit is the answer and is not a guess.
                        if (!ans_r) begin
                            ans_s = 1'b1;
                        end else if (gcnt_r < GMAX) begin
                            gcnt_s = gcnt_r + 4'd1;
                        end else begin
                            gcnt_s = gcnt_r;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end
                KEY_CLEAR: begin
                    dig1_s  = 4'h0;
                    dig2_s  = 4'h0;
                    dig3_s  = 4'h0;
                    state_s = EMPTY;
                end
                // Codes outside the keypad alphabet are rejected like any bad key.
                KEY_ILL_D, KEY_ILL_E, KEY_ILL_F: begin
                    err_s = 1'b1;
                end
                default: begin
                    if (state_r == FULL) begin
                        err_s = 1'b1;
                    end else if (REPEAT_CHECK &&
                                 is_dup(bus.key_code, state_r, dig1_r, dig2_r, dig3_r)) begin
                        err_s = 1'b1;
                    end else begin
                        case (state_r)
                            EMPTY: begin
                                dig1_s  = bus.key_code;
                                state_s = ONE;
                            end
                            ONE: begin
                                dig2_s  = bus.key_code;
                                state_s = TWO;
                            end
                            TWO: begin
                                dig3_s  = bus.key_code;
                                state_s = FULL;
                            end
                            default: err_s = 1'b1;
                        endcase
                    end
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // Registered alongside the count so it never lags it by a cycle.
        locked_s = (gcnt_s == GMAX);
    end

    assign bus.oNum1   = num1_r;
    assign bus.oNum2   = num2_r;
    assign bus.oNum3   = num3_r;
    assign bus.oNumRdy = rdy_r;
    assign oDig1       = dig1_r;
    assign oDig2       = dig2_r;
    assign oDig3       = dig3_r;
    assign oDigCnt     = state_r;
    assign oErr        = err_r;
    assign oGuessCnt   = gcnt_r;
    assign oLocked     = locked_r;

endmodule
